cfu_l1_to_l2_shim: RTL and testbench

//   Upstream adapter that lets a CPU/CFU-L2 requester (valid/ready both ways) drive a

---
 rtl/cfu_l1_to_l2_shim.sv | 120 ++++++++++++
 tb/tb_cfu_l1_to_l2_shim.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_l1_to_l2_shim.sv
// rtl/cfu_l1_to_l2_shim.sv - credit-gated L2 requester to fixed-latency L1 CFU adapter
package cfu_pkg;
    typedef enum logic [1:0] {
        CFU_OK            = 2'd0,
        CFU_ERROR_INVALID = 2'd1,
        CFU_ERROR_STATE   = 2'd2,
        CFU_ERROR_OTHER   = 2'd3
    } cfu_status_t;
endpackage

module cfu_l1_to_l2_shim
    import cfu_pkg::*;
#(
    parameter int CFU_LATENCY    = 0,
    parameter int CFU_STATE_ID_W = 1,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_DATA_W     = 32,
    parameter int FIFO_DEPTH     = CFU_LATENCY + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CFU_STATE_ID_W-1:0] req_state,
    input  logic [CFU_FUNC_ID_W-1:0]  req_func,
    input  logic [CFU_DATA_W-1:0]     req_data0,
    input  logic [CFU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output cfu_status_t               resp_status,
    output logic [CFU_DATA_W-1:0]     resp_data,
    output logic                      l1_clk_en,
    output logic                      l1_req_valid,
    output logic [CFU_STATE_ID_W-1:0] l1_req_state,
    output logic [CFU_FUNC_ID_W-1:0]  l1_req_func,
    output logic [CFU_DATA_W-1:0]     l1_req_data0,
    output logic [CFU_DATA_W-1:0]     l1_req_data1,
    input  logic                      l1_resp_valid,
    input  cfu_status_t               l1_resp_status,
    input  logic [CFU_DATA_W-1:0]     l1_resp_data,
    output logic                      err_unexp
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam bit               ZERO_LAT = (CFU_LATENCY == 0);

    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        used;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    cfu_status_t           status_mem [SLOTS];
    logic [CFU_DATA_W-1:0] data_mem   [SLOTS];
    logic                  issue;
    logic                  resp_expected;
    logic                  push;
    logic                  pop;

    // A request is only issued when its response is guaranteed a FIFO slot.
    assign used      = {1'b0, inflight} + {1'b0, count};
    assign req_ready = clk_en && (used < DEPTH_C);
    assign issue     = req_valid && req_ready;

    assign l1_clk_en    = clk_en;
    assign l1_req_valid = issue;
    assign l1_req_state = req_state;
    assign l1_req_func  = req_func;
    assign l1_req_data0 = req_data0;
    assign l1_req_data1 = req_data1;

    // A zero-latency core answers in the issue cycle, before inflight has counted it.
    assign resp_expected = (inflight != '0) || (ZERO_LAT && issue);
    assign push          = clk_en && l1_resp_valid && resp_expected;
    assign pop           = clk_en && resp_valid && resp_ready;

    assign resp_valid  = (count != '0);
    assign resp_status = status_mem[rd_ptr];
    assign resp_data   = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_unexp <= 1'b0;
        end else if (clk_en) begin
            if (issue && !push) begin
                inflight <= inflight + 1'b1;
            end else if (push && !issue) begin
                inflight <= inflight - 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (l1_resp_valid && !resp_expected) begin
                err_unexp <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            status_mem[wr_ptr] <= l1_resp_status;
            data_mem[wr_ptr]   <= l1_resp_data;
        end
    end
endmodule

// File: tb/tb_cfu_l1_to_l2_shim.sv
// tb/tb_cfu_l1_to_l2_shim.sv - directed and randomized bench for cfu_l1_to_l2_shim
`timescale 1ns/1ps
module tb_cfu_l1_to_l2_shim;
    import cfu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        cfu_status_t st;
        logic [31:0] res;
        logic [31:0] acc;
    } mac_t;

    typedef struct {
        logic [9:0]  func;
        logic [31:0] d0;
        logic [31:0] d1;
        cfu_status_t st;
        logic [31:0] res;
    } vec_t;

    typedef struct packed {
        cfu_status_t st;
        logic [31:0] res;
    } rsp_t;

    // Multiply-accumulate L1 core: 0 mul, 1 mulacc, 2 read_state, others invalid.
    function automatic mac_t mac(input logic [9:0] f, input logic [31:0] acc,
                                 input logic [31:0] a, input logic [31:0] b);
        mac_t r;
        r.st  = CFU_OK;
        r.acc = acc;
        r.res = acc;
        case (f)
            10'd0: begin r.acc = a * b; r.res = a * b; end
            10'd1: begin r.acc = acc + a * b; r.res = acc + a * b; end
            10'd2: r.res = acc;
            default: begin r.st = CFU_ERROR_INVALID; r.res = 32'd0; end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: latency 2, depth 4 ----------------
    logic a_clk_en, a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_err_unexp;
    logic [0:0] a_req_state, a_l1_req_state;
    logic [9:0] a_req_func, a_l1_req_func;
    logic [31:0] a_req_data0, a_req_data1, a_resp_data, a_l1_req_data0, a_l1_req_data1, a_l1_resp_data;
    logic a_l1_clk_en, a_l1_req_valid, a_l1_resp_valid, a_force;
    cfu_status_t a_resp_status, a_l1_resp_status;
    logic [1:0] a_v;
    cfu_status_t a_st [0:1];
    logic [31:0] a_d [0:1];
    logic [31:0] a_acc;
    mac_t a_m;

    cfu_l1_to_l2_shim #(.CFU_LATENCY(2), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .clk_en(a_clk_en),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_state(a_req_state),
        .req_func(a_req_func), .req_data0(a_req_data0), .req_data1(a_req_data1),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_status(a_resp_status), .resp_data(a_resp_data),
        .l1_clk_en(a_l1_clk_en), .l1_req_valid(a_l1_req_valid), .l1_req_state(a_l1_req_state),
        .l1_req_func(a_l1_req_func), .l1_req_data0(a_l1_req_data0), .l1_req_data1(a_l1_req_data1),
        .l1_resp_valid(a_l1_resp_valid), .l1_resp_status(a_l1_resp_status),
        .l1_resp_data(a_l1_resp_data), .err_unexp(a_err_unexp)
    );

    assign a_m = mac(a_l1_req_func, a_acc, a_l1_req_data0, a_l1_req_data1);
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v   <= 2'b00;
            a_acc <= 32'd0;
        end else if (a_l1_clk_en) begin
            a_v     <= {a_v[0], a_l1_req_valid};
            a_st[1] <= a_st[0];
            a_st[0] <= a_m.st;
            a_d[1]  <= a_d[0];
            a_d[0]  <= a_m.res;
            if (a_l1_req_valid) a_acc <= a_m.acc;
        end
    end
    assign a_l1_resp_valid  = a_v[1] | a_force;
    assign a_l1_resp_status = a_st[1];
    assign a_l1_resp_data   = a_d[1];

    // ---------------- instance B: latency 0, depth 1 ----------------
    logic b_clk_en, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_err_unexp;
    logic [0:0] b_req_state, b_l1_req_state;
    logic [9:0] b_req_func, b_l1_req_func;
    logic [31:0] b_req_data0, b_req_data1, b_resp_data, b_l1_req_data0, b_l1_req_data1, b_l1_resp_data;
    logic b_l1_clk_en, b_l1_req_valid, b_l1_resp_valid;
    cfu_status_t b_resp_status, b_l1_resp_status;
    logic [31:0] b_acc;
    mac_t b_m;

    cfu_l1_to_l2_shim #(.CFU_LATENCY(0), .FIFO_DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .clk_en(b_clk_en),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_state(b_req_state),
        .req_func(b_req_func), .req_data0(b_req_data0), .req_data1(b_req_data1),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_status(b_resp_status), .resp_data(b_resp_data),
        .l1_clk_en(b_l1_clk_en), .l1_req_valid(b_l1_req_valid), .l1_req_state(b_l1_req_state),
        .l1_req_func(b_l1_req_func), .l1_req_data0(b_l1_req_data0), .l1_req_data1(b_l1_req_data1),
        .l1_resp_valid(b_l1_resp_valid), .l1_resp_status(b_l1_resp_status),
        .l1_resp_data(b_l1_resp_data), .err_unexp(b_err_unexp)
    );

    assign b_m = mac(b_l1_req_func, b_acc, b_l1_req_data0, b_l1_req_data1);
    always_ff @(posedge clk) begin
        if (rst) b_acc <= 32'd0;
        else if (b_l1_clk_en && b_l1_req_valid) b_acc <= b_m.acc;
    end
    assign b_l1_resp_valid  = b_l1_req_valid;
    assign b_l1_resp_status = b_m.st;
    assign b_l1_resp_data   = b_m.res;

    // ---------------- instance C: latency 1, depth 3 ----------------
    logic c_clk_en, c_req_valid, c_req_ready, c_resp_valid, c_resp_ready, c_err_unexp;
    logic [0:0] c_req_state, c_l1_req_state;
    logic [9:0] c_req_func, c_l1_req_func;
    logic [31:0] c_req_data0, c_req_data1, c_resp_data, c_l1_req_data0, c_l1_req_data1, c_l1_resp_data;
    logic c_l1_clk_en, c_l1_req_valid, c_l1_resp_valid;
    cfu_status_t c_resp_status, c_l1_resp_status;
    logic c_v;
    cfu_status_t c_st;
    logic [31:0] c_d, c_acc;
    mac_t c_m;

    cfu_l1_to_l2_shim #(.CFU_LATENCY(1), .FIFO_DEPTH(3)) u_c (
        .clk(clk), .rst(rst), .clk_en(c_clk_en),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_state(c_req_state),
        .req_func(c_req_func), .req_data0(c_req_data0), .req_data1(c_req_data1),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
        .resp_status(c_resp_status), .resp_data(c_resp_data),
        .l1_clk_en(c_l1_clk_en), .l1_req_valid(c_l1_req_valid), .l1_req_state(c_l1_req_state),
        .l1_req_func(c_l1_req_func), .l1_req_data0(c_l1_req_data0), .l1_req_data1(c_l1_req_data1),
        .l1_resp_valid(c_l1_resp_valid), .l1_resp_status(c_l1_resp_status),
        .l1_resp_data(c_l1_resp_data), .err_unexp(c_err_unexp)
    );

    assign c_m = mac(c_l1_req_func, c_acc, c_l1_req_data0, c_l1_req_data1);
    always_ff @(posedge clk) begin
        if (rst) begin
            c_v   <= 1'b0;
            c_acc <= 32'd0;
        end else if (c_l1_clk_en) begin
            c_v  <= c_l1_req_valid;
            c_st <= c_m.st;
            c_d  <= c_m.res;
            if (c_l1_req_valid) c_acc <= c_m.acc;
        end
    end
    assign c_l1_resp_valid  = c_v;
    assign c_l1_resp_status = c_st;
    assign c_l1_resp_data   = c_d;

    task automatic do_reset();
        a_clk_en = 1; a_req_valid = 0; a_resp_ready = 1; a_force = 0;
        a_req_state = 0; a_req_func = 0; a_req_data0 = 0; a_req_data1 = 0;
        b_clk_en = 1; b_req_valid = 0; b_resp_ready = 1;
        b_req_state = 0; b_req_func = 0; b_req_data0 = 0; b_req_data1 = 0;
        c_clk_en = 1; c_req_valid = 0; c_resp_ready = 1;
        c_req_state = 0; c_req_func = 0; c_req_data0 = 0; c_req_data1 = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    vec_t tv[5];
    logic [31:0] exp_b [8];
    rsp_t exp_q[$];
    rsp_t got;
    mac_t sm;
    logic [31:0] sb_acc, tmp_acc;
    int acc_n, rsp_n, last_acc, resp_due;
    logic c_took;

    initial begin
        tv[0] = '{10'd0, 32'd3,  32'd5,  CFU_OK,            32'd15};
        tv[1] = '{10'd1, 32'd2,  32'd7,  CFU_OK,            32'd29};
        tv[2] = '{10'd2, 32'd0,  32'd0,  CFU_OK,            32'd29};
        tv[3] = '{10'd9, 32'd1,  32'd1,  CFU_ERROR_INVALID, 32'd0};
        tv[4] = '{10'd1, 32'd10, 32'd10, CFU_OK,            32'd129};

        // Reset and idle
        do_reset();
        #1;
        chk("a_idle_req_ready", a_req_ready, 1);
        chk("a_idle_resp_valid", a_resp_valid, 0);
        chk("a_idle_l1_req_valid", a_l1_req_valid, 0);
        chk("a_idle_err", a_err_unexp, 0);
        chk("b_idle_req_ready", b_req_ready, 1);
        chk("c_idle_resp_valid", c_resp_valid, 0);

        // Back-to-back mulacc sequence, responses at t+3
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            a_req_valid = (k < 5);
            if (k < 5) begin
                a_req_func  = tv[k].func;
                a_req_data0 = tv[k].d0;
                a_req_data1 = tv[k].d1;
                a_req_state = 1'(k);
            end
            #1;
            if (k < 5) begin
                chk("a_tbl_req_ready", a_req_ready, 1);
                chk("a_tbl_l1_req_valid", a_l1_req_valid, 1);
                chk("a_tbl_l1_fields", {a_l1_req_state, a_l1_req_func, a_l1_req_data0},
                    {1'(k), tv[k].func, tv[k].d0});
            end
            if (k >= 3 && k < 8) begin
                chk("a_tbl_resp_valid", a_resp_valid, 1);
                chk("a_tbl_resp_status", a_resp_status, tv[k-3].st);
                chk("a_tbl_resp_data", a_resp_data, tv[k-3].res);
            end else begin
                chk("a_tbl_resp_idle", a_resp_valid, 0);
            end
        end

        // clk_en low blocks issue and freezes state
        a_req_valid = 1; a_clk_en = 0;
        #1;
        chk("a_ce_req_ready", a_req_ready, 0);
        chk("a_ce_l1_req_valid", a_l1_req_valid, 0);
        chk("a_ce_l1_clk_en", a_l1_clk_en, 0);
        repeat (3) @(posedge clk);
        #1;
        a_req_valid = 0; a_clk_en = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("a_ce_no_resp", a_resp_valid, 0);

        // Backpressure: only 4 credits, then drain and resume
        do_reset();
        a_resp_ready = 0;
        acc_n = 0; rsp_n = 0;
        for (int cyc = 0; cyc < 300 && rsp_n < 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 15) a_resp_ready = 1;
            a_req_valid = (acc_n < 10);
            a_req_func  = 10'd0;
            a_req_data0 = 32'(acc_n + 1);
            a_req_data1 = 32'd2;
            #1;
            if (cyc == 14) begin
                chk("a_bp_accepted", 64'(acc_n), 64'd4);
                chk("a_bp_req_ready", a_req_ready, 0);
            end
            if (a_req_valid && a_req_ready) acc_n++;
            if (a_resp_valid && a_resp_ready) begin
                chk("a_bp_resp_data", a_resp_data, 64'(2 * rsp_n + 2));
                rsp_n++;
            end
        end
        a_req_valid = 0;
        chk("a_bp_all_resp", 64'(rsp_n), 64'd10);

        // Latency 0, depth 1: one accept every two cycles
        do_reset();
        tmp_acc = 0;
        for (int i = 0; i < 8; i++) begin
            tmp_acc = tmp_acc + 32'(i + 1) * 32'd3;
            exp_b[i] = tmp_acc;
        end
        acc_n = 0; rsp_n = 0; last_acc = -10; resp_due = -10;
        for (int cyc = 0; cyc < 60 && rsp_n < 8; cyc++) begin
            @(posedge clk); #1;
            b_req_valid = (acc_n < 8);
            b_req_func  = 10'd1;
            b_req_data0 = 32'(acc_n + 1);
            b_req_data1 = 32'd3;
            #1;
            if (b_resp_valid) begin
                chk("b_resp_cycle", 64'(cyc), 64'(resp_due));
                chk("b_resp_data", b_resp_data, exp_b[rsp_n]);
                rsp_n++;
            end
            if (b_req_valid && b_req_ready) begin
                if (acc_n > 0) chk("b_accept_spacing", 64'(cyc - last_acc), 64'd2);
                last_acc = cyc;
                resp_due = cyc + 1;
                acc_n++;
            end
        end
        b_req_valid = 0;
        chk("b_all_resp", 64'(rsp_n), 64'd8);
        chk("b_err", b_err_unexp, 0);

        // Depth 3 with random backpressure and clock enable
        do_reset();
        sb_acc = 0; acc_n = 0; rsp_n = 0; c_took = 0;
        for (int cyc = 0; cyc < 20000 && rsp_n < 1000; cyc++) begin
            @(posedge clk); #1;
            if (c_took) c_req_valid = 0;
            c_took = 0;
            c_clk_en     = ($urandom_range(0, 4) != 0);
            c_resp_ready = 1'($urandom_range(0, 1));
            if (!c_req_valid && acc_n < 1000 && $urandom_range(0, 3) != 0) begin
                c_req_valid = 1;
                c_req_func  = ($urandom_range(0, 3) == 3) ? 10'd9 : 10'($urandom_range(0, 2));
                c_req_data0 = $urandom_range(0, 1000);
                c_req_data1 = $urandom_range(0, 1000);
                c_req_state = 1'($urandom_range(0, 1));
            end
            #1;
            if (!c_clk_en) chk("c_ce_req_ready", c_req_ready, 0);
            if (c_resp_valid && c_resp_ready && c_clk_en) begin
                got = '{c_resp_status, c_resp_data};
                if (exp_q.size() == 0) begin
                    chk("c_unexpected_resp", 1, 0);
                end else begin
                    chk("c_resp", got, exp_q.pop_front());
                end
                rsp_n++;
            end
            if (c_req_valid && c_req_ready) begin
                sm = mac(c_req_func, sb_acc, c_req_data0, c_req_data1);
                sb_acc = sm.acc;
                exp_q.push_back('{sm.st, sm.res});
                acc_n++;
                c_took = 1;
            end
        end
        @(posedge clk); #1;
        c_req_valid = 0; c_clk_en = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("c_all_resp", 64'(rsp_n), 64'd1000);
        chk("c_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("c_drained", c_resp_valid, 0);
        chk("c_err", c_err_unexp, 0);

        // Reset with 2 in flight and 1 queued, then unexpected response
        do_reset();
        a_resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            a_req_valid = 1; a_req_func = 10'd0;
            a_req_data0 = 32'(k + 1); a_req_data1 = 32'd1;
        end
        @(posedge clk); #1;
        a_req_valid = 0;
        #1;
        chk("a_pre_rst_queued", a_resp_valid, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("a_rst_resp_valid", a_resp_valid, 0);
        chk("a_rst_req_ready", a_req_ready, 1);
        a_resp_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("a_rst_no_stale", a_resp_valid, 0);
        chk("a_rst_no_err", a_err_unexp, 0);
        a_force = 1;
        @(posedge clk); #1;
        a_force = 0;
        #1;
        chk("a_unexp_err", a_err_unexp, 1);
        chk("a_unexp_dropped", a_resp_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_unexp_sticky", a_err_unexp, 1);
        do_reset();
        #1;
        chk("a_unexp_cleared", a_err_unexp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
